traffic_light_monitor: RTL and testbench

- Receiving-end checker for the two-LED `traffic` controller output bus.
- Decodes the 6-bit active-low RGB pattern back into a phase, measures each phase's dwell in seconds, and flags illegal patterns, out-of-order phases and wrong durations.
- Sits beside the controller in the top level (and in benches) as an on-chip protocol monitor. It is clocked by the fast system clock and samples only on a 1 Hz tick strobe.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/traffic_light_monitor_if.sv | 29 ++
 rtl/traffic_led_decode.sv | 22 ++
 rtl/traffic_light_monitor.sv | 137 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the two-LED traffic controller and its receiving-end monitor.
package traffic_pkg;

    localparam int CNT_W = 5;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

    // Active-low RGB, {LED2[2:0], LED1[2:0]}.
    localparam logic [5:0] LED_S1 = 6'b101011;
    localparam logic [5:0] LED_S2 = 6'b110011;
    localparam logic [5:0] LED_S3 = 6'b011101;
    localparam logic [5:0] LED_S4 = 6'b011110;

    localparam logic [CNT_W-1:0] T_S1 = CNT_W'(15);
    localparam logic [CNT_W-1:0] T_S2 = CNT_W'(3);
    localparam logic [CNT_W-1:0] T_S3 = CNT_W'(10);
    localparam logic [CNT_W-1:0] T_S4 = CNT_W'(3);
    localparam logic [CNT_W-1:0] DWELL_MAX = '1;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } mon_state_e;

    function automatic logic [CNT_W-1:0] phase_dwell(input logic [1:0] ph);
        case (ph)
            PH_0:    return T_S1;
            PH_1:    return T_S2;
            PH_2:    return T_S3;
            default: return T_S4;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Controller-output bus as seen by the monitor, plus the monitor's status outputs.
interface traffic_light_monitor_if;
    import traffic_pkg::*;

    // tick qualifies led: the monitor samples led only on clk edges with tick=1;
    // every status pulse below is valid for exactly the one clk following such an edge.
    logic             tick;
    logic [5:0]       led;
    logic [1:0]       phase;
    logic             locked;
    logic [CNT_W-1:0] dwell;
    logic             err_pat;
    logic             err_seq;
    logic             err_time;
    logic             err_sticky;
    logic             cycle_ok;
    mon_state_e       state;

    modport master (
        output tick, led,
        input  phase, locked, dwell, err_pat, err_seq, err_time, err_sticky, cycle_ok, state
    );

    modport slave (
        input  tick, led,
        output phase, locked, dwell, err_pat, err_seq, err_time, err_sticky, cycle_ok, state
    );

endinterface

// File: rtl/traffic_led_decode.sv
// Maps a 6-bit LED pattern to its phase code; anything else is illegal.
module traffic_led_decode
    import traffic_pkg::*;
(
    input  logic [5:0] led_i,
    output logic       legal_o,
    output logic [1:0] code_o
);

    always_comb begin
        legal_o = 1'b1;
        code_o  = PH_0;
        case (led_i)
            LED_S1:  code_o = PH_0;
            LED_S2:  code_o = PH_1;
            LED_S3:  code_o = PH_2;
            LED_S4:  code_o = PH_3;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Protocol monitor for the traffic controller: tracks phase order and dwell per 1 Hz tick.
module traffic_light_monitor
    import traffic_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    traffic_light_monitor_if.slave   bus
);

    logic             dec_legal;
    logic [1:0]       dec_code;

    mon_state_e       state_q;
    logic [1:0]       phase_q;
    logic             locked_q;
    logic [CNT_W-1:0] dwell_q;
    logic             partial_q;
    logic             clean_q;
    logic             armed_q;
    logic             err_pat_q;
    logic             err_seq_q;
    logic             err_time_q;
    logic             err_sticky_q;
    logic             cycle_ok_q;

    logic [1:0]       succ_d;
    logic [CNT_W-1:0] t_cur_d;
    logic [CNT_W-1:0] dwell_inc_d;
    logic             overrun_d;
    logic             short_d;

    traffic_led_decode u_decode (
        .led_i   (bus.led),
        .legal_o (dec_legal),
        .code_o  (dec_code)
    );

    // The first (partial) phase after lock has unknown history, so its timing is never judged.
    always_comb begin
        succ_d      = phase_q + 2'd1;
        t_cur_d     = phase_dwell(phase_q);
        dwell_inc_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + CNT_W'(1);
        overrun_d   = !partial_q && (dwell_q == t_cur_d);
        short_d     = !partial_q && (dwell_q < t_cur_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            phase_q      <= PH_0;
            locked_q     <= 1'b0;
            dwell_q      <= '0;
            partial_q    <= 1'b0;
            clean_q      <= 1'b0;
            armed_q      <= 1'b0;
            err_pat_q    <= 1'b0;
            err_seq_q    <= 1'b0;
            err_time_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            cycle_ok_q   <= 1'b0;
        end else begin
            err_pat_q  <= 1'b0;
            err_seq_q  <= 1'b0;
            err_time_q <= 1'b0;
            cycle_ok_q <= 1'b0;
            if (bus.tick) begin
                case (state_q)
                    ST_SYNC: begin
                        if (!dec_legal) begin
                            err_pat_q    <= 1'b1;
                            err_sticky_q <= 1'b1;
                        end else begin
                            state_q   <= ST_TRACK;
                            phase_q   <= dec_code;
                            dwell_q   <= CNT_W'(1);
                            locked_q  <= 1'b1;
                            partial_q <= 1'b1;
                            clean_q   <= 1'b1;
                            armed_q   <= 1'b0;
                        end
                    end
                    ST_TRACK: begin
                        if (!dec_legal) begin
                            err_pat_q    <= 1'b1;
                            err_sticky_q <= 1'b1;
                            state_q      <= ST_SYNC;
                            locked_q     <= 1'b0;
                            dwell_q      <= '0;
                        end else if (dec_code == phase_q) begin
                            dwell_q <= dwell_inc_d;
                            if (overrun_d) begin
                                err_time_q   <= 1'b1;
                                err_sticky_q <= 1'b1;
                                clean_q      <= 1'b0;
                            end
                        end else if (dec_code == succ_d) begin
                            phase_q   <= dec_code;
                            dwell_q   <= CNT_W'(1);
                            partial_q <= 1'b0;
                            if (short_d) begin
                                err_time_q   <= 1'b1;
                                err_sticky_q <= 1'b1;
                            end
                            // Entering phase 0 closes one cycle and opens the next.
                            if (dec_code == PH_0) begin
                                cycle_ok_q <= armed_q && clean_q && !short_d;
                                clean_q    <= 1'b1;
                                armed_q    <= 1'b1;
                            end else if (short_d) begin
                                clean_q <= 1'b0;
                            end
                        end else begin
                            err_seq_q    <= 1'b1;
                            err_sticky_q <= 1'b1;
                            phase_q      <= dec_code;
                            dwell_q      <= CNT_W'(1);
                            partial_q    <= 1'b0;
                            clean_q      <= 1'b0;
                        end
                    end
                    default: state_q <= ST_SYNC;
                endcase
            end
        end
    end

    assign bus.phase      = phase_q;
    assign bus.locked     = locked_q;
    assign bus.dwell      = dwell_q;
    assign bus.err_pat    = err_pat_q;
    assign bus.err_seq    = err_seq_q;
    assign bus.err_time   = err_time_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.cycle_ok   = cycle_ok_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized scoreboard bench for traffic_light_monitor against a run-length reference model.
module tb_traffic_light_monitor;

    localparam int W = 13;
    localparam int K_LOCK = 0;
    localparam int K_SUCC = 1;
    localparam int K_SEQ  = 2;

    logic clk = 1'b0;
    logic rst_n;

    traffic_light_monitor_if bus();

    traffic_light_monitor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [5:0] led_pat [4] = '{6'b101011, 6'b110011, 6'b011101, 6'b011110};
    int         t_req   [4] = '{15, 3, 10, 3};

    // Model state: the list of phase runs seen since the last lock.
    typedef struct {
        int code;
        int len;
        int kind;
    } run_t;

    run_t       runs[$];
    logic [W-1:0] exp_q[$];
    int         m_locked;
    int         m_phase;
    int         m_sticky;
    int         checks   = 0;
    int         failures = 0;
    bit         mon_on   = 1'b0;

    function automatic int decode(input logic [5:0] l);
        for (int k = 0; k < 4; k++) if (l == led_pat[k]) return k;
        return -1;
    endfunction

    // A clean cycle is four back-to-back runs 0,1,2,3 of exact length, the 0-run entered normally.
    function automatic bit cycle_complete();
        int n;
        n = runs.size();
        if (n < 4) return 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (runs[n-4+k].code != k || runs[n-4+k].len != t_req[k]) return 1'b0;
        end
        return runs[n-4].kind == K_SUCC;
    endfunction

    task automatic model_reset();
        runs.delete();
        m_locked = 0;
        m_phase  = 0;
        m_sticky = 0;
    endtask

    task automatic push_run(input int c, input int kind);
        run_t r;
        r.code = c;
        r.len  = 1;
        r.kind = kind;
        runs.push_back(r);
        if (runs.size() > 6) void'(runs.pop_front());
        m_phase = c;
    endtask

    task automatic model_step(input bit tk, input logic [5:0] l);
        bit ep, es, et, co;
        int c, n, dw;
        logic [1:0] ph;
        logic [4:0] dw5;
        ep = 0; es = 0; et = 0; co = 0;
        if (tk) begin
            c = decode(l);
            if (m_locked == 0) begin
                if (c < 0) ep = 1;
                else begin
                    runs.delete();
                    push_run(c, K_LOCK);
                    m_locked = 1;
                end
            end else begin
                n = runs.size();
                if (c < 0) begin
                    ep = 1;
                    m_locked = 0;
                end else if (c == runs[n-1].code) begin
                    runs[n-1].len = runs[n-1].len + 1;
                    if (runs[n-1].kind != K_LOCK && runs[n-1].len == t_req[c] + 1) et = 1;
                end else if (c == (runs[n-1].code + 1) % 4) begin
                    if (runs[n-1].kind != K_LOCK && runs[n-1].len < t_req[runs[n-1].code]) et = 1;
                    if (c == 0 && cycle_complete()) co = 1;
                    push_run(c, K_SUCC);
                end else begin
                    es = 1;
                    push_run(c, K_SEQ);
                end
            end
        end
        if (ep || es || et) m_sticky = 1;
        dw = 0;
        if (m_locked != 0) dw = (runs[runs.size()-1].len > 31) ? 31 : runs[runs.size()-1].len;
        ph  = 2'(m_phase);
        dw5 = 5'(dw);
        exp_q.push_back({ph, (m_locked != 0), dw5, ep, es, et, (m_sticky != 0), co});
    endtask

    function automatic logic [W-1:0] dut_word();
        return {bus.phase, bus.locked, bus.dwell, bus.err_pat, bus.err_seq,
                bus.err_time, bus.err_sticky, bus.cycle_ok};
    endfunction

    task automatic compare(input string name, input logic [W-1:0] e);
        logic [W-1:0] g;
        g = dut_word();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s @%0t: got phase=%0d locked=%0b dwell=%0d pat=%0b seq=%0b time=%0b sticky=%0b ok=%0b; expected phase=%0d locked=%0b dwell=%0d pat=%0b seq=%0b time=%0b sticky=%0b ok=%0b",
                     name, $time, g[12:11], g[10], g[9:5], g[4], g[3], g[2], g[1], g[0],
                     e[12:11], e[10], e[9:5], e[4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic cycle_drive(input bit tk, input logic [5:0] l);
        @(negedge clk);
        bus.tick = tk;
        bus.led  = l;
        model_step(tk, l);
    endtask

    task automatic send(input logic [5:0] l);
        repeat ($urandom_range(0, 2)) cycle_drive(1'b0, 6'($urandom));
        cycle_drive(1'b1, l);
    endtask

    task automatic run_phase(input int p, input int n);
        repeat (n) send(led_pat[p]);
    endtask

    task automatic cycle_with(input int l0, input int l1, input int l2, input int l3);
        run_phase(0, l0);
        run_phase(1, l1);
        run_phase(2, l2);
        run_phase(3, l3);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n    = 1'b0;
        bus.tick = 1'b1;
        bus.led  = led_pat[0];
        model_reset();
        model_step(1'b0, led_pat[0]);
        #1;
        compare("async_reset", '0);
        @(negedge clk);
        rst_n    = 1'b1;
        bus.tick = 1'b0;
        model_step(1'b0, bus.led);
    endtask

    initial begin
        logic [W-1:0] e;
        wait (mon_on);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow @%0t: got no expected entry, required one", $time);
            end else begin
                e = exp_q.pop_front();
                compare("scoreboard", e);
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int p, len, r;
        logic [5:0] l;
        rst_n    = 1'b0;
        bus.tick = 1'b0;
        bus.led  = 6'h00;
        model_reset();
        model_step(1'b0, 6'h00);
        mon_on = 1'b1;
        @(negedge clk);
        compare("reset_state", '0);
        rst_n = 1'b1;
        model_step(1'b0, 6'h00);

        // Nominal three cycles plus the return to phase 0, then reset mid-phase.
        repeat (3) cycle_with(15, 3, 10, 3);
        run_phase(0, 3);
        reset_pulse();

        // Mid-phase start, then two full cycles.
        run_phase(0, 7);
        cycle_with(0, 3, 10, 3);
        cycle_with(15, 3, 10, 3);
        run_phase(0, 15);

        // Phase 1 overrun, then phase 2 short, then clean cycles.
        cycle_with(0, 4, 10, 3);
        cycle_with(15, 3, 9, 3);
        cycle_with(15, 3, 10, 3);
        cycle_with(15, 3, 10, 3);
        run_phase(0, 5);

        // Sequence jump, then illegal pattern and relock.
        run_phase(2, 10);
        run_phase(3, 3);
        send(6'b111111);
        send(led_pat[1]);
        send(6'b000000);
        send(6'b000000);
        run_phase(1, 2);
        cycle_with(0, 0, 10, 3);
        cycle_with(15, 3, 10, 3);
        run_phase(0, 1);

        // Random mix of nominal, off-by-one, jumps and illegal samples.
        p = 0;
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                p   = (p + 1) % 4;
                len = t_req[p] + $urandom_range(0, 2) - 1;
                if (r < 4) len = t_req[p];
                run_phase(p, len);
            end else if (r == 7) begin
                p   = (p + 2 + $urandom_range(0, 1)) % 4;
                run_phase(p, $urandom_range(1, t_req[p]));
            end else begin
                l = 6'($urandom);
                if (decode(l) >= 0) l = 6'h3f;
                send(l);
            end
        end

        reset_pulse();
        run_phase(1, 2);
        cycle_with(15, 3, 10, 3);
        run_phase(0, 1);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
